// File: rtl/cpu_pkg.sv
// Shared encodings for the multicycle CPU: opcodes, control FSM states, instruction
// field positions and the per-state control decode.
package cpu_pkg;

  localparam int INSTR_W = 8;
  localparam int OP_HI   = 7;
  localparam int OP_LO   = 6;
  localparam int RS_HI   = 5;
  localparam int RS_LO   = 4;
  localparam int RT_HI   = 3;
  localparam int RT_LO   = 2;
  localparam int RD_HI   = 1;
  localparam int RD_LO   = 0;
  localparam int JOFF_W  = 6;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_LW  = 2'b01,
    OP_SW  = 2'b10,
    OP_JMP = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_e;

  typedef struct packed {
    logic instr_ready;
    logic busy;
    logic regdst;
    logic regwrite;
    logic alusrc;
    logic memread;
    logic memwrite;
    logic memtoreg;
  } ctrl_t;

  function automatic op_e ir_op(input logic [INSTR_W-1:0] ir);
    return op_e'(ir[OP_HI:OP_LO]);
  endfunction

  // Controls that belong to a given state; evaluated on the next state so they can be registered.
  function automatic ctrl_t ctrl_decode(input state_e st, input logic [INSTR_W-1:0] ir);
    ctrl_t c;
    op_e   op;
    c      = '0;
    op     = ir_op(ir);
    c.busy = (st != ST_FETCH);
    case (st)
      ST_FETCH: c.instr_ready = 1'b1;
      ST_EXEC:  c.alusrc = (op == OP_LW) || (op == OP_SW);
      ST_MEM: begin
        c.alusrc   = 1'b1;
        c.memread  = (op == OP_LW);
        c.memwrite = (op == OP_SW);
      end
      ST_WB: begin
        c.regwrite = 1'b1;
        c.regdst   = (op == OP_ADD);
        c.memtoreg = (op == OP_LW);
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_control_pc_next.sv
// Next program counter: plain increment, or increment plus a sign-extended relative offset.
module pc_next
  import cpu_pkg::*;
#(
  parameter int PC_WIDTH = 8
) (
  input  logic [PC_WIDTH-1:0] pc,
  input  logic [JOFF_W-1:0]   offset,
  input  logic                jump,
  output logic [PC_WIDTH-1:0] next_pc
);

  logic [PC_WIDTH-1:0] pc_inc;
  logic [PC_WIDTH-1:0] off_ext;

  assign pc_inc  = pc + PC_WIDTH'(1);
  assign off_ext = PC_WIDTH'($signed(offset));
  assign next_pc = jump ? (pc_inc + off_ext) : pc_inc;

endmodule

// File: rtl/multicycle_control.sv
// Multicycle CPU control FSM: fetch handshake, instruction register, sequencing through
// decode/execute/memory/writeback, and registered datapath controls.
module multicycle_control
  import cpu_pkg::*;
#(
  parameter int PC_WIDTH = 8
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [7:0]          instr,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic                mem_ack,
  output logic [PC_WIDTH-1:0] pc,
  output logic [1:0]          read_register1,
  output logic [1:0]          read_register2,
  output logic [1:0]          destination_register,
  output logic                regdst,
  output logic                regwrite,
  output logic                alusrc,
  output logic                memread,
  output logic                memwrite,
  output logic                memtoreg,
  output logic [7:0]          imm,
  output logic                busy
);

  state_e              state_q, state_d;
  logic [7:0]          ir_q, ir_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d, pc_nxt;
  ctrl_t               ctrl_q, ctrl_d;
  logic                pc_adv, pc_jmp;
  op_e                 op;

  assign op = ir_op(ir_q);

  pc_next #(.PC_WIDTH(PC_WIDTH)) u_pc_next (
    .pc      (pc_q),
    .offset  (ir_q[JOFF_W-1:0]),
    .jump    (pc_jmp),
    .next_pc (pc_nxt)
  );

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    pc_adv  = 1'b0;
    pc_jmp  = 1'b0;
    case (state_q)
      ST_FETCH: begin
        if (instr_valid) begin
          ir_d    = instr;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: state_d = ST_EXEC;
      ST_EXEC: begin
        case (op)
          OP_ADD:       state_d = ST_WB;
          OP_LW, OP_SW: state_d = ST_MEM;
          default: begin
            state_d = ST_FETCH;
            pc_adv  = 1'b1;
            pc_jmp  = 1'b1;
          end
        endcase
      end
      ST_MEM: begin
        // A store retires straight out of MEM; a load still needs its writeback cycle.
        if (mem_ack) begin
          state_d = (op == OP_LW) ? ST_WB : ST_FETCH;
          pc_adv  = (op != OP_LW);
        end
      end
      ST_WB: begin
        state_d = ST_FETCH;
        pc_adv  = 1'b1;
      end
      default: state_d = ST_FETCH;
    endcase
    pc_d   = pc_adv ? pc_nxt : pc_q;
    ctrl_d = ctrl_decode(state_d, ir_d);
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= ST_FETCH;
      ir_q    <= '0;
      pc_q    <= '0;
      ctrl_q  <= ctrl_decode(ST_FETCH, '0);
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      pc_q    <= pc_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign pc                   = pc_q;
  assign read_register1       = ir_q[RS_HI:RS_LO];
  assign read_register2       = ir_q[RT_HI:RT_LO];
  assign destination_register = ir_q[RD_HI:RD_LO];
  assign imm                  = {{6{ir_q[RD_HI]}}, ir_q[RD_HI:RD_LO]};
  assign instr_ready          = ctrl_q.instr_ready;
  assign busy                 = ctrl_q.busy;
  assign regdst               = ctrl_q.regdst;
  assign regwrite             = ctrl_q.regwrite;
  assign alusrc               = ctrl_q.alusrc;
  assign memread              = ctrl_q.memread;
  assign memwrite             = ctrl_q.memwrite;
  assign memtoreg             = ctrl_q.memtoreg;

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The module SHALL have parameter PC_WIDTH, default 8, giving the program counter width.
REQ-002 The module SHALL have port CLK, input, width 1: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port RESET, input, width 1: asynchronous, active-low reset.
REQ-004 The module SHALL have port instr, input, width 8: instruction word; op=[7:6], rs=[5:4], rt=[3:2], rd=[1:0].
REQ-005 The module SHALL have port instr_valid, input, width 1: instr is valid this cycle.
REQ-006 The module SHALL have port instr_ready, output, width 1: the block accepts instr this cycle.
REQ-007 The module SHALL have port mem_ack, input, width 1: the data memory completes the pending access.
REQ-008 The module SHALL have port pc, output, width PC_WIDTH: address of the next instruction to fetch.
REQ-009 The module SHALL have ports read_register1, read_register2 and destination_register, outputs, width 2 each: rs, rt and rd of the latched instruction.
REQ-010 The module SHALL have ports regdst, regwrite, alusrc, memread, memwrite and memtoreg, outputs, width 1 each: datapath controls.
REQ-011 The module SHALL have port imm, output, width 8: IR[1:0] sign-extended to 8 bits.
REQ-012 The module SHALL have port busy, output, width 1: high in every state except FETCH.

Function
REQ-013 The ops SHALL be: 00 ADD (rd=rs+rt), 01 LW (rt=mem[rs+imm]), 10 SW (mem[rs+imm]=rt), 11 JMP (pc-relative).
REQ-014 The FSM states SHALL be FETCH, DECODE, EXEC, MEM and WB.
REQ-015 In FETCH the block SHALL hold instr_ready=1 and all other controls 0; when instr_valid=1 it SHALL latch instr into the IR and go to DECODE; otherwise it stays in FETCH.
REQ-016 In states other than FETCH, instr_ready SHALL be 0 and instr_valid SHALL be ignored.
REQ-017 The IR SHALL hold its value from the accept edge until the next accept, and register-select outputs SHALL be driven from the IR.
REQ-018 DECODE SHALL last exactly one cycle and then go to EXEC.
REQ-019 In EXEC, alusrc SHALL be 1 for LW and SW and 0 otherwise.
REQ-020 From EXEC, ADD SHALL go to WB, LW and SW SHALL go to MEM, and JMP SHALL go to FETCH.
REQ-021 On JMP the block SHALL set pc = pc + 1 + sign_extend(IR[5:0]), modulo 2^PC_WIDTH.
REQ-022 In MEM the block SHALL hold memread (LW) or memwrite (SW) and alusrc=1 until mem_ack=1 is sampled in MEM, with unbounded wait.
REQ-023 mem_ack sampled outside MEM SHALL be ignored.
REQ-024 After MEM, LW SHALL go to WB and SW SHALL go to FETCH.
REQ-025 WB SHALL last exactly one cycle with regwrite=1; regdst=1 and memtoreg=0 for ADD; regdst=0 and memtoreg=1 for LW.
REQ-026 regwrite SHALL be 1 only in WB.
REQ-027 For ADD, LW and SW, pc SHALL increment by 1 on the edge leaving the final state (WB, or MEM for SW), wrapping from 2^PC_WIDTH-1 to 0.
REQ-028 Cycle counts SHALL be, counting the accept cycle: ADD 4; JMP 3; SW 4+wait; LW 5+wait.
REQ-029 All outputs SHALL be registered or decoded from state and IR only, with no combinational path from instr or mem_ack to any output.

Reset
REQ-030 RESET=0 SHALL immediately force state=FETCH, pc=0, IR=0, regwrite=memread=memwrite=0.
REQ-031 RESET=0 mid-instruction, including in MEM awaiting mem_ack or in WB, SHALL abort the instruction with no regwrite pulse.
REQ-032 After RESET deasserts, the first rising edge SHALL perform a normal FETCH-state evaluation.

Structure
REQ-033 Op encodings, state encodings and field bit positions SHALL live in a shared package (cpu_pkg), also used by the datapath and register file.
REQ-034 PC next-value logic (increment or relative jump) SHALL be a natural sub-module named pc_next; everything else SHALL stay in one FSM.

Verification
REQ-035 Scenario ADD: instr=8'b00_01_10_11 with instr_valid=1 -> regwrite=1 with regdst=1, destination_register=3, read_register1=1, read_register2=2 in cycle 4; pc goes 0->1.
REQ-036 Scenario LW with wait: instr=8'b01_00_01_11, mem_ack high after 3 MEM cycles -> memread held 3 cycles; imm=8'hFF; WB with regdst=0 and memtoreg=1; exactly one regwrite pulse.
REQ-037 Scenario JMP: pc=5, instr=8'b11_111110 -> pc=4 after 3 cycles; no regwrite, memread or memwrite.
REQ-038 Scenario PC wrap: pc=255, ADD -> pc=0; JMP with offset +0 at pc=255 -> pc=0.
REQ-039 Scenario reset in MEM: SW waiting, RESET=0 pulse -> state FETCH, pc=0 and memwrite=0 asynchronously; a later mem_ack is ignored.
REQ-040 Scenario handshake: instr_valid held high throughout -> exactly one instruction accepted per FETCH visit; instr changes while busy=1 do not affect the IR.
